// File: rtl/game_pkg.sv
// Shared definitions for the falling-ball game: state encoding, score format
// and default timing, so that every consumer decodes state/cd_digit the same way.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int BCD_W        = 4;
  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W      = BCD_W * SCORE_DIGITS;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;
  localparam logic [1:0]         CD_START  = 2'd3;

  localparam int DEF_FRAME_DIV         = 1666667;
  localparam int DEF_COUNT_STEP_FRAMES = 60;
  localparam int DEF_SCORE_FRAMES      = 60;
  localparam int DEF_LEVEL_UP_SCORE    = 10;
  localparam int DEF_MAX_LEVEL         = 7;
  localparam int DEF_SCROLL_BASE       = 8;

  // Bits needed to hold any value 0..n (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter that increments by one and sticks at 9999.
module bcd_counter4
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] value,
  output logic               sat
);

  logic [SCORE_W-1:0] value_inc;
  logic               carry;

  // Ripple a +1 through the digits, wrapping any 9 to 0 and carrying on.
  always_comb begin
    value_inc = value;
    carry     = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (value[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
          value_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          value_inc[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + BCD_W'(1);
          carry = 1'b0;
        end
      end
    end
  end

  assign sat = (value == SCORE_MAX);

  // Score register: clear wins, increments are dropped once saturated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !sat) begin
      value <= value_inc;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: idle, 3-2-1 countdown, play, pause and game over,
// plus the frame/scroll timebase, world reset, score and difficulty level.
module game_sequencer
  import game_pkg::*;
#(
  parameter int FRAME_DIV         = DEF_FRAME_DIV,
  parameter int COUNT_STEP_FRAMES = DEF_COUNT_STEP_FRAMES,
  parameter int SCORE_FRAMES      = DEF_SCORE_FRAMES,
  parameter int LEVEL_UP_SCORE    = DEF_LEVEL_UP_SCORE,
  parameter int MAX_LEVEL         = DEF_MAX_LEVEL,
  parameter int SCROLL_BASE       = DEF_SCROLL_BASE
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               key_start,
  input  logic               key_pause,
  input  logic               fail,
  output logic               run_en,
  output logic               world_rstn,
  output logic               frame_tick,
  output logic               scroll_tick,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         level,
  output logic [2:0]         state,
  output logic [1:0]         cd_digit,
  output logic               game_over
);

  localparam int FRW = cnt_width(FRAME_DIV - 1);
  localparam int STW = cnt_width(COUNT_STEP_FRAMES);
  localparam int SVW = cnt_width(SCORE_FRAMES);
  localparam int LPW = cnt_width(LEVEL_UP_SCORE);
  localparam int SCW = cnt_width(SCROLL_BASE);

  state_t           cur_state, nxt_state;
  logic [FRW-1:0]   frame_cnt;
  logic             keys_armed, key_start_q, key_pause_q;
  logic             start_p, pause_p;
  logic [STW-1:0]   step_cnt, step_nxt;
  logic [SVW-1:0]   surv_cnt, surv_nxt;
  logic [SCW-1:0]   scroll_cnt, scroll_nxt, scroll_limit;
  logic [LPW-1:0]   lvl_pts, lvl_pts_nxt;
  logic [2:0]       level_nxt;
  logic [1:0]       cd_nxt;
  logic             world_rstn_nxt, scroll_tick_nxt;
  logic             score_clr, score_inc, score_sat;
  logic             begin_game;

  assign state     = cur_state;
  assign run_en    = (cur_state == ST_PLAY);
  assign game_over = (cur_state == ST_OVER);

  // Free-running frame divider; the tick marks the cycle the counter wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else if (frame_cnt == FRW'(FRAME_DIV - 1)) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b1;
    end else begin
      frame_cnt  <= frame_cnt + FRW'(1);
      frame_tick <= 1'b0;
    end
  end

  // Key rising-edge pulses; the arm flag hides a key already held at reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      keys_armed  <= 1'b0;
      key_start_q <= 1'b0;
      key_pause_q <= 1'b0;
      start_p     <= 1'b0;
      pause_p     <= 1'b0;
    end else begin
      keys_armed  <= 1'b1;
      key_start_q <= key_start;
      key_pause_q <= key_pause;
      start_p     <= key_start & ~key_start_q & keys_armed;
      pause_p     <= key_pause & ~key_pause_q & keys_armed;
    end
  end

  // Scroll period shrinks with level but never below one frame.
  always_comb begin
    scroll_limit = SCW'(1);
    if (SCROLL_BASE > int'(level) + 1) begin
      scroll_limit = SCW'(SCROLL_BASE - int'(level));
    end
  end

  // Next-state and next-value logic for the game flow.
  always_comb begin
    nxt_state       = cur_state;
    cd_nxt          = cd_digit;
    step_nxt        = step_cnt;
    surv_nxt        = surv_cnt;
    scroll_nxt      = scroll_cnt;
    lvl_pts_nxt     = lvl_pts;
    level_nxt       = level;
    world_rstn_nxt  = 1'b1;
    scroll_tick_nxt = 1'b0;
    score_clr       = 1'b0;
    score_inc       = 1'b0;
    begin_game      = 1'b0;

    unique case (cur_state)
      ST_IDLE: begin
        if (start_p) begin
          begin_game = 1'b1;
        end
      end

      ST_COUNT: begin
        if (frame_tick) begin
          if (step_cnt + STW'(1) == STW'(COUNT_STEP_FRAMES)) begin
            step_nxt = '0;
            if (cd_digit == 2'd1) begin
              nxt_state  = ST_PLAY;
              cd_nxt     = 2'd0;
              surv_nxt   = '0;
              scroll_nxt = '0;
            end else begin
              cd_nxt = cd_digit - 2'd1;
            end
          end else begin
            step_nxt = step_cnt + STW'(1);
          end
        end
      end

      ST_PLAY: begin
        if (fail) begin
          nxt_state = ST_OVER;
        end else if (pause_p) begin
          nxt_state = ST_PAUSE;
        end else if (frame_tick) begin
          if (surv_cnt + SVW'(1) == SVW'(SCORE_FRAMES)) begin
            surv_nxt = '0;
            if (!score_sat) begin
              score_inc = 1'b1;
              if (lvl_pts + LPW'(1) == LPW'(LEVEL_UP_SCORE)) begin
                lvl_pts_nxt = '0;
                if (level < 3'(MAX_LEVEL)) begin
                  level_nxt = level + 3'd1;
                end
              end else begin
                lvl_pts_nxt = lvl_pts + LPW'(1);
              end
            end
          end else begin
            surv_nxt = surv_cnt + SVW'(1);
          end
          if (scroll_cnt + SCW'(1) >= scroll_limit) begin
            scroll_nxt      = '0;
            scroll_tick_nxt = 1'b1;
          end else begin
            scroll_nxt = scroll_cnt + SCW'(1);
          end
        end
      end

      ST_PAUSE: begin
        if (start_p) begin
          nxt_state = ST_IDLE;
        end else if (pause_p) begin
          nxt_state = ST_PLAY;
        end
      end

      ST_OVER: begin
        if (start_p) begin
          begin_game = 1'b1;
        end
      end

      default: begin
        nxt_state = ST_IDLE;
      end
    endcase

    if (begin_game) begin
      nxt_state      = ST_COUNT;
      cd_nxt         = CD_START;
      step_nxt       = '0;
      lvl_pts_nxt    = '0;
      level_nxt      = 3'd0;
      score_clr      = 1'b1;
      world_rstn_nxt = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Counters and registered outputs that move with the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cd_digit    <= 2'd0;
      step_cnt    <= '0;
      surv_cnt    <= '0;
      scroll_cnt  <= '0;
      lvl_pts     <= '0;
      level       <= 3'd0;
      world_rstn  <= 1'b1;
      scroll_tick <= 1'b0;
    end else begin
      cd_digit    <= cd_nxt;
      step_cnt    <= step_nxt;
      surv_cnt    <= surv_nxt;
      scroll_cnt  <= scroll_nxt;
      lvl_pts     <= lvl_pts_nxt;
      level       <= level_nxt;
      world_rstn  <= world_rstn_nxt;
      scroll_tick <= scroll_tick_nxt;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (score_clr),
    .inc   (score_inc),
    .value (score),
    .sat   (score_sat)
  );

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a small-timing instance walks the whole
// game flow, a second instance scoring every frame runs into score saturation.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        key_start = 1'b0, key_pause = 1'b0, fail = 1'b0;
  logic        run_en, world_rstn, frame_tick, scroll_tick, game_over;
  logic [15:0] score;
  logic [2:0]  level, state;
  logic [1:0]  cd_digit;

  logic        s_key_start = 1'b0, s_key_pause = 1'b0, s_fail = 1'b0;
  logic        s_run_en, s_world_rstn, s_frame_tick, s_scroll_tick, s_game_over;
  logic [15:0] s_score;
  logic [2:0]  s_level, s_state;
  logic [1:0]  s_cd_digit;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .FRAME_DIV(4), .COUNT_STEP_FRAMES(2), .SCORE_FRAMES(2),
    .LEVEL_UP_SCORE(2), .MAX_LEVEL(7), .SCROLL_BASE(3)
  ) dut (
    .clk(clk), .rstn(rstn), .key_start(key_start), .key_pause(key_pause),
    .fail(fail), .run_en(run_en), .world_rstn(world_rstn),
    .frame_tick(frame_tick), .scroll_tick(scroll_tick), .score(score),
    .level(level), .state(state), .cd_digit(cd_digit), .game_over(game_over)
  );

  game_sequencer #(
    .FRAME_DIV(2), .COUNT_STEP_FRAMES(1), .SCORE_FRAMES(1),
    .LEVEL_UP_SCORE(2), .MAX_LEVEL(7), .SCROLL_BASE(3)
  ) dut_sat (
    .clk(clk), .rstn(rstn), .key_start(s_key_start), .key_pause(s_key_pause),
    .fail(s_fail), .run_en(s_run_en), .world_rstn(s_world_rstn),
    .frame_tick(s_frame_tick), .scroll_tick(s_scroll_tick), .score(s_score),
    .level(s_level), .state(s_state), .cd_digit(s_cd_digit), .game_over(s_game_over)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    total++; if (score !== 16'h0) begin bad++; $display("[TB] FAIL reset_score: got %0h expected 0", score); end
    total++; if (level !== 3'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    total++; if (cd_digit !== 2'd0) begin bad++; $display("[TB] FAIL reset_cd: got %0d expected 0", cd_digit); end
    total++; if ({run_en, world_rstn, frame_tick, scroll_tick, game_over} !== 5'b01000) begin
      bad++; $display("[TB] FAIL reset_flags: got %b expected 01000", {run_en, world_rstn, frame_tick, scroll_tick, game_over});
    end
    rstn = 1'b1;
    cyc  = 0;
  endtask

  task automatic test_frame_timer();
    while (cyc < 12) begin
      tick();
      total++; if (frame_tick !== (cyc % 4 == 0)) begin
        bad++; $display("[TB] FAIL frame_tick@%0d: got %b expected %b", cyc, frame_tick, (cyc % 4 == 0));
      end
      total++; if (state !== 3'd0 || world_rstn !== 1'b1 || run_en !== 1'b0) begin
        bad++; $display("[TB] FAIL idle_quiet@%0d: got state=%0d wr=%b run=%b expected 0/1/0", cyc, state, world_rstn, run_en);
      end
    end
  endtask

  task automatic test_start_countdown();
    logic [1:0] prev_cd;
    logic [1:0] exp_cd;
    int         ticks;
    bit         reached;
    key_start = 1'b1;
    tick();
    total++; if (state !== 3'd0 || world_rstn !== 1'b1) begin
      bad++; $display("[TB] FAIL start_latency: got state=%0d wr=%b expected 0/1", state, world_rstn);
    end
    tick();
    key_start = 1'b0;
    total++; if (state !== 3'd1 || world_rstn !== 1'b0 || cd_digit !== 2'd3) begin
      bad++; $display("[TB] FAIL start_enter: got state=%0d wr=%b cd=%0d expected 1/0/3", state, world_rstn, cd_digit);
    end
    prev_cd = 2'd3;
    ticks   = 0;
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 0) begin
        total++; if (world_rstn !== 1'b1) begin bad++; $display("[TB] FAIL world_rstn_width: got %b expected 1", world_rstn); end
      end
      if (state == 3'd2) begin
        reached = 1'b1;
        break;
      end
      if (cd_digit != prev_cd) begin
        exp_cd = prev_cd - 2'd1;
        total++; if (cd_digit !== exp_cd || ticks != (prev_cd == 2'd3 ? 2 : 4)) begin
          bad++; $display("[TB] FAIL cd_step: got cd=%0d after %0d ticks expected %0d after %0d", cd_digit, ticks, exp_cd, (prev_cd == 2'd3 ? 2 : 4));
        end
        prev_cd = cd_digit;
      end
      if (frame_tick) ticks++;
    end
    total++; if (!reached || ticks != 6 || cyc != 37) begin
      bad++; $display("[TB] FAIL play_entry: got reached=%b ticks=%0d cyc=%0d expected 1/6/37", reached, ticks, cyc);
    end
    total++; if (run_en !== 1'b1 || cd_digit !== 2'd0) begin
      bad++; $display("[TB] FAIL play_outputs: got run=%b cd=%0d expected 1/0", run_en, cd_digit);
    end
  endtask

  task automatic test_play_scoring();
    logic exp_st;
    while (cyc < 74) begin
      tick();
      exp_st = (cyc == 49 || cyc == 57 || cyc == 65 || cyc == 73);
      total++; if (scroll_tick !== exp_st) begin
        bad++; $display("[TB] FAIL scroll_tick@%0d: got %b expected %b", cyc, scroll_tick, exp_st);
      end
      if (cyc == 45) begin
        total++; if (score !== 16'h0001 || level !== 3'd0) begin bad++; $display("[TB] FAIL score1: got %0h/L%0d expected 1/L0", score, level); end
      end
      if (cyc == 53) begin
        total++; if (score !== 16'h0002 || level !== 3'd1) begin bad++; $display("[TB] FAIL score2: got %0h/L%0d expected 2/L1", score, level); end
      end
      if (cyc == 69) begin
        total++; if (score !== 16'h0004 || level !== 3'd2) begin bad++; $display("[TB] FAIL score4: got %0h/L%0d expected 4/L2", score, level); end
      end
    end
  endtask

  task automatic test_pause_resume();
    int scrolls;
    int ticks;
    bit moved;
    key_pause = 1'b1;
    tick();
    tick();
    key_pause = 1'b0;
    total++; if (state !== 3'd3 || run_en !== 1'b0) begin
      bad++; $display("[TB] FAIL pause_enter: got state=%0d run=%b expected 3/0", state, run_en);
    end
    scrolls = 0; ticks = 0; moved = 1'b0;
    while (cyc < 116) begin
      tick();
      if (scroll_tick) scrolls++;
      if (frame_tick) ticks++;
      if (score !== 16'h0004 || level !== 3'd2 || state !== 3'd3) moved = 1'b1;
    end
    total++; if (scrolls != 0 || moved || ticks != 10) begin
      bad++; $display("[TB] FAIL pause_frozen: got scrolls=%0d moved=%b ticks=%0d expected 0/0/10", scrolls, moved, ticks);
    end
    key_pause = 1'b1;
    tick();
    tick();
    key_pause = 1'b0;
    total++; if (state !== 3'd2 || run_en !== 1'b1) begin
      bad++; $display("[TB] FAIL resume: got state=%0d run=%b expected 2/1", state, run_en);
    end
    tick();
    tick();
    total++; if (score !== 16'h0004) begin bad++; $display("[TB] FAIL resume_hold: got %0h expected 4", score); end
    tick();
    total++; if (score !== 16'h0005 || scroll_tick !== 1'b1) begin
      bad++; $display("[TB] FAIL resume_continue: got score=%0h scroll=%b expected 5/1", score, scroll_tick);
    end
  endtask

  task automatic test_fail_priority();
    key_pause = 1'b1;
    tick();
    fail = 1'b1;
    tick();
    fail = 1'b0;
    key_pause = 1'b0;
    total++; if (state !== 3'd4 || game_over !== 1'b1 || run_en !== 1'b0) begin
      bad++; $display("[TB] FAIL fail_over: got state=%0d go=%b run=%b expected 4/1/0", state, game_over, run_en);
    end
    while (cyc < 130) tick();
    total++; if (score !== 16'h0005 || level !== 3'd2 || state !== 3'd4) begin
      bad++; $display("[TB] FAIL over_hold: got %0h/L%0d/s%0d expected 5/L2/s4", score, level, state);
    end
  endtask

  task automatic test_restart_from_over();
    key_start = 1'b1;
    tick();
    tick();
    key_start = 1'b0;
    total++; if (state !== 3'd1 || world_rstn !== 1'b0 || score !== 16'h0 || level !== 3'd0 || cd_digit !== 2'd3) begin
      bad++; $display("[TB] FAIL restart: got s%0d wr=%b %0h L%0d cd%0d expected s1 wr=0 0 L0 cd3", state, world_rstn, score, level, cd_digit);
    end
    tick();
    total++; if (world_rstn !== 1'b1) begin bad++; $display("[TB] FAIL restart_pulse: got %b expected 1", world_rstn); end
  endtask

  task automatic test_async_reset();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (state == 3'd2 && score == 16'h0002) begin ok = 1'b1; break; end
    end
    total++; if (!ok || level !== 3'd1) begin
      bad++; $display("[TB] FAIL replay_reach: got ok=%b level=%0d expected 1/1", ok, level);
    end
    #2 rstn = 1'b0;
    #1;
    total++; if (state !== 3'd0 || score !== 16'h0 || level !== 3'd0 || cd_digit !== 2'd0) begin
      bad++; $display("[TB] FAIL async_regs: got s%0d %0h L%0d cd%0d expected 0", state, score, level, cd_digit);
    end
    total++; if ({run_en, world_rstn, frame_tick, scroll_tick, game_over} !== 5'b01000) begin
      bad++; $display("[TB] FAIL async_flags: got %b expected 01000", {run_en, world_rstn, frame_tick, scroll_tick, game_over});
    end
  endtask

  task automatic test_key_held_at_reset();
    @(negedge clk);
    key_start = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    cyc  = 0;
    repeat (8) begin
      tick();
      total++; if (state !== 3'd0 || world_rstn !== 1'b1) begin
        bad++; $display("[TB] FAIL held_key@%0d: got s%0d wr=%b expected 0/1", cyc, state, world_rstn);
      end
    end
    key_start = 1'b0;
  endtask

  task automatic test_saturation();
    bit reached;
    int digit_bad;
    s_key_start = 1'b1;
    reached   = 1'b0;
    digit_bad = 0;
    for (int i = 0; i < 25000; i++) begin
      tick();
      if (i == 4) s_key_start = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (s_score[d*4 +: 4] > 4'd9) digit_bad++;
      end
      if (s_score == 16'h9999) begin reached = 1'b1; break; end
    end
    total++; if (!reached || digit_bad != 0) begin
      bad++; $display("[TB] FAIL sat_reach: got reached=%b bad_digits=%0d score=%0h expected 1/0/9999", reached, digit_bad, s_score);
    end
    total++; if (s_level !== 3'd7) begin bad++; $display("[TB] FAIL sat_level: got %0d expected 7", s_level); end
    repeat (20) tick();
    total++; if (s_score !== 16'h9999 || s_level !== 3'd7) begin
      bad++; $display("[TB] FAIL sat_hold: got %0h/L%0d expected 9999/L7", s_score, s_level);
    end
    total++; if (s_state !== 3'd2 || s_run_en !== 1'b1 || s_game_over !== 1'b0 || s_cd_digit !== 2'd0) begin
      bad++; $display("[TB] FAIL sat_state: got s%0d run=%b go=%b cd=%0d expected 2/1/0/0", s_state, s_run_en, s_game_over, s_cd_digit);
    end
  endtask

  initial begin
    test_reset();
    test_frame_timer();
    test_start_countdown();
    test_play_scoring();
    test_pause_resume();
    test_fail_priority();
    test_restart_from_over();
    test_async_reset();
    test_key_held_at_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
